// File: rtl/image_stream_scheduler.sv
// Buffers one image from the AXI write side and streams its nonzero pixels to the coprocessor as (addr, value) events.
// Events are registered and issued at most one per cycle. pix_ready alone throttles STREAM; pixel writes are accepted only in IDLE.
module image_stream_scheduler #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = 8,
  parameter int RESULT_BITS     = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [IMAGE_SIZE_BITS-1:0] wr_addr,
  input  logic [PIXEL_BITS-1:0]      wr_data,
  input  logic                       clr_buf,
  input  logic                       start,
  output logic                       busy,
  input  logic                       coprocessor_rdy,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [IMAGE_SIZE_BITS-1:0] pix_addr,
  output logic [PIXEL_BITS-1:0]      pix_data,
  output logic                       image_done,
  input  logic                       inference_done,
  input  logic [RESULT_BITS-1:0]     inference_result,
  output logic                       result_valid,
  output logic [RESULT_BITS-1:0]     result_data,
  input  logic                       result_ack,
  output logic [IMAGE_SIZE_BITS:0]   event_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PIXEL_BITS-1:0]      pix_buf [IMAGE_SIZE];
  logic [IMAGE_SIZE_BITS-1:0] ptr;
  logic [IMAGE_SIZE_BITS-1:0] ptr_inc;
  logic [PIXEL_BITS-1:0]      cur_pix;
  logic [PIXEL_BITS-1:0]      nxt_pix;
  logic                       go;
  logic                       skip;
  logic                       load;
  logic                       hs;
  logic                       at_last;
  logic                       advance;
  logic                       reload;
  logic                       stream_end;
  logic                       buf_wr;
  logic                       buf_clr;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start)           state_nxt = WAIT_RDY;
      WAIT_RDY:  if (coprocessor_rdy) state_nxt = STREAM;
      STREAM:    if (stream_end)      state_nxt = WAIT_DONE;
      WAIT_DONE: if (inference_done)  state_nxt = HOLD;
      HOLD:      if (result_ack)      state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // A handshake on pixel p looks ahead at p+1 so consecutive nonzero pixels issue back to back.
  always_comb begin
    ptr_inc    = ptr + 1'b1;
    cur_pix    = pix_buf[ptr];
    nxt_pix    = pix_buf[ptr_inc];
    at_last    = (ptr == IMAGE_SIZE_BITS'(IMAGE_SIZE - 1));
    go         = (state == IDLE) && start;
    skip       = (state == STREAM) && !pix_valid && (cur_pix == '0);
    load       = (state == STREAM) && !pix_valid && (cur_pix != '0);
    hs         = (state == STREAM) && pix_valid && pix_ready;
    advance    = (skip || hs) && !at_last;
    reload     = hs && !at_last && (nxt_pix != '0);
    stream_end = (skip || hs) && at_last;
    buf_wr     = wr_valid && wr_ready;
    buf_clr    = (state == IDLE) && clr_buf;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || buf_clr) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        pix_buf[i] <= '0;
      end
    end else if (buf_wr) begin
      pix_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ready     <= 1'b1;
      busy         <= 1'b0;
      ptr          <= '0;
      pix_valid    <= 1'b0;
      pix_addr     <= '0;
      pix_data     <= '0;
      image_done   <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      event_count  <= '0;
    end else begin
      wr_ready   <= (state_nxt == IDLE);
      busy       <= (state_nxt != IDLE);
      image_done <= stream_end;

      if (go) begin
        ptr         <= '0;
        event_count <= '0;
        result_data <= '0;
      end else if (advance) begin
        ptr <= ptr_inc;
      end

      if (hs) begin
        event_count <= event_count + 1'b1;
      end

      if (load) begin
        pix_valid <= 1'b1;
        pix_addr  <= ptr;
        pix_data  <= cur_pix;
      end else if (hs) begin
        pix_valid <= reload;
        if (reload) begin
          pix_addr <= ptr_inc;
          pix_data <= nxt_pix;
        end
      end

      if ((state == WAIT_DONE) && inference_done) begin
        result_valid <= 1'b1;
        result_data  <= inference_result;
      end else if ((state == HOLD) && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_stream_scheduler.sv
// Bench for image_stream_scheduler: a pixel-array model predicts the event list, event count and result path.
module tb_image_stream_scheduler;
  localparam int N = 256;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic       clr_buf = 1'b0;
  logic       start = 1'b0;
  logic       coprocessor_rdy = 1'b0;
  logic       pix_ready = 1'b0;
  logic       inference_done = 1'b0;
  logic       result_ack = 1'b0;
  logic [7:0] wr_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] inference_result = 8'd0;
  logic       wr_ready, busy, pix_valid, image_done, result_valid;
  logic [7:0] pix_addr, pix_data, result_data;
  logic [8:0] event_count;

  int checks = 0;
  int failures = 0;
  int mem [N];
  int ev_addr[$];
  int ev_data[$];
  int done_cnt;
  int done_delta;
  int stab_err;

  image_stream_scheduler dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_buf(clr_buf), .start(start), .busy(busy), .coprocessor_rdy(coprocessor_rdy),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_data(pix_data),
    .image_done(image_done), .inference_done(inference_done),
    .inference_result(inference_result), .result_valid(result_valid),
    .result_data(result_data), .result_ack(result_ack), .event_count(event_count)
  );

  always #5 aclk = ~aclk;

  task automatic write_pix(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = 8'(a);
    wr_data  = 8'(d);
    @(negedge aclk);
    wr_valid = 1'b0;
    mem[a] = d;
  endtask

  task automatic do_start(input logic rdy);
    start = 1'b1;
    coprocessor_rdy = rdy;
    @(negedge aclk);
    start = 1'b0;
  endtask

  // Drives pix_ready per mode (0 always, 1 toggle, 2 random) and records every handshake.
  task automatic stream_collect(input int mode);
    int k = 0;
    bit r;
    bit stall = 1'b0;
    logic [7:0] sa = 8'd0;
    logic [7:0] sd = 8'd0;
    ev_addr.delete();
    ev_data.delete();
    done_cnt = 0;
    done_delta = -1;
    stab_err = 0;
    coprocessor_rdy = 1'b1;
    while (done_cnt == 0 && k < 3000) begin
      @(negedge aclk);
      k++;
      if (image_done === 1'b1) begin
        done_cnt++;
        done_delta = k - 1;
      end
      if (stall && (pix_valid !== 1'b1 || pix_addr !== sa || pix_data !== sd)) stab_err++;
      case (mode)
        0:       r = 1'b1;
        1:       r = k[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (done_cnt != 0) r = 1'b0;
      pix_ready = r;
      if (pix_valid === 1'b1 && r) begin
        ev_addr.push_back(int'(pix_addr));
        ev_data.push_back(int'(pix_data));
      end
      stall = (pix_valid === 1'b1) && !r;
      sa = pix_addr;
      sd = pix_data;
    end
    coprocessor_rdy = 1'b0;
    pix_ready = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      if (image_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL image_done_pulses got=%0d want=1", done_cnt);
    end
    checks++;
    if (stab_err !== 0) begin
      failures++;
      $display("FAIL event_stability unstable_cycles=%0d want=0", stab_err);
    end
  endtask

  task automatic check_events(input string tag);
    int exp_a[$];
    int exp_d[$];
    int bad = 0;
    int first = -1;
    for (int i = 0; i < N; i++) begin
      if (mem[i] != 0) begin
        exp_a.push_back(i);
        exp_d.push_back(mem[i]);
      end
    end
    checks++;
    if (ev_addr.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL %s num_events got=%0d want=%0d", tag, ev_addr.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < ev_addr.size(); i++) begin
      if (ev_addr[i] != exp_a[i] || ev_data[i] != exp_d[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s event_list bad=%0d first idx=%0d got=(%0d,%0h) want=(%0d,%0h)", tag, bad,
               first, ev_addr[first], ev_data[first], exp_a[first], exp_d[first]);
    end
    checks++;
    if (int'(event_count) !== exp_a.size()) begin
      failures++;
      $display("FAIL %s event_count got=%0d want=%0d", tag, event_count, exp_a.size());
    end
  endtask

  task automatic finish_result(input logic [7:0] res, input int delay);
    int bad = 0;
    inference_done = 1'b1;
    inference_result = res;
    for (int i = 0; i < delay; i++) begin
      @(negedge aclk);
      inference_done = 1'b0;
      if (!(result_valid === 1'b1 && result_data === res && busy === 1'b1)) bad++;
    end
    result_ack = 1'b1;
    @(negedge aclk);
    result_ack = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL result_hold bad_cycles=%0d data=%0h want=%0h", bad, result_data, res);
    end
    checks++;
    if ({result_valid, busy, wr_ready} !== 3'b001) begin
      failures++;
      $display("FAIL result_release got valid/busy/wr_ready=%b want=001", {result_valid, busy, wr_ready});
    end
    checks++;
    if (result_data !== res) begin
      failures++;
      $display("FAIL result_data_kept got=%0h want=%0h", result_data, res);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({wr_ready, busy, pix_valid, result_valid, image_done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=10000", {wr_ready, busy, pix_valid, result_valid, image_done});
    end
    checks++;
    if ({event_count, pix_addr, pix_data, result_data} !== 33'd0) begin
      failures++;
      $display("FAIL reset_values cnt=%0d addr=%0h data=%0h res=%0h want all 0", event_count,
               pix_addr, pix_data, result_data);
    end
    aresetn = 1'b1;
    do_start(1'b1);
    stream_collect(0);
    check_events("reset_empty");
    checks++;
    if (done_delta !== N) begin
      failures++;
      $display("FAIL all_zero_latency got=%0d want=%0d", done_delta, N);
    end
    finish_result(8'($urandom), 2);
  endtask

  task automatic test_sparse();
    write_pix(3, 8'h10);
    write_pix(200, 8'hFF);
    do_start(1'b1);
    stream_collect(0);
    check_events("sparse");
    checks++;
    if (done_delta < N + 1 || done_delta > N + 3) begin
      failures++;
      $display("FAIL sparse_latency got=%0d want=%0d..%0d", done_delta, N + 1, N + 3);
    end
  endtask

  task automatic test_result_path();
    finish_result(8'h07, 5);
    do_start(1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL second_start busy got=%b want=1", busy);
    end
    stream_collect(2);
    check_events("second_image");
    finish_result(8'h5C, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) write_pix(i, 1);
    do_start(1'b1);
    stream_collect(1);
    check_events("backpressure");
    finish_result(8'h21, 3);
  endtask

  task automatic test_back_to_back();
    do_start(1'b1);
    stream_collect(0);
    check_events("back_to_back");
    checks++;
    if (done_delta < N || done_delta > N + 2) begin
      failures++;
      $display("FAIL back_to_back_latency got=%0d want=%0d..%0d", done_delta, N, N + 2);
    end
    finish_result(8'h99, 1);
  endtask

  task automatic test_ready_gating();
    int bad = 0;
    write_pix(5, 8'h33);
    do_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (pix_valid !== 1'b0 || busy !== 1'b1 || wr_ready !== 1'b0 || result_valid !== 1'b0) bad++;
      wr_valid = (i == 3);
      wr_addr = 8'd5;
      wr_data = 8'h77;
      inference_done = (i == 3);
      start = (i == 8);
    end
    wr_valid = 1'b0;
    inference_done = 1'b0;
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL ready_gating bad_cycles=%0d want=0", bad);
    end
    stream_collect(2);
    check_events("write_lockout");
    finish_result(8'h42, 2);
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      clr_buf = 1'b1;
      @(negedge aclk);
      clr_buf = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = 0;
      for (int i = 0; i < 40; i++) begin
        write_pix(int'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)));
      end
      do_start(1'b1);
      stream_collect(2);
      check_events("random");
      finish_result(8'($urandom), int'($urandom_range(1, 4)));
    end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    int spurious = 0;
    write_pix(10, 8'h5A);
    do_start(1'b1);
    pix_ready = 1'b0;
    while (pix_valid !== 1'b1 && k < 400) begin
      @(negedge aclk);
      k++;
    end
    checks++;
    if (pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_event_wait got pix_valid=%b want=1", pix_valid);
    end
    aresetn = 1'b0;
    coprocessor_rdy = 1'b0;
    @(negedge aclk);
    checks++;
    if ({pix_valid, busy, wr_ready, image_done} !== 4'b0010) begin
      failures++;
      $display("FAIL mid_reset_abort got=%b want=0010", {pix_valid, busy, wr_ready, image_done});
    end
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 0;
    repeat (300) begin
      @(negedge aclk);
      if (image_done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL mid_reset_quiet bad_cycles=%0d want=0", spurious);
    end
    do_start(1'b1);
    stream_collect(0);
    check_events("after_reset");
    finish_result(8'h11, 1);
  endtask

  task automatic test_clear();
    write_pix(7, 8'h44);
    write_pix(8, 8'h45);
    clr_buf = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 8'd9;
    wr_data = 8'h99;
    @(negedge aclk);
    clr_buf = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 0;
    do_start(1'b1);
    stream_collect(0);
    check_events("clear");
    finish_result(8'h01, 1);
    wr_valid = 1'b1;
    wr_addr = 8'd100;
    wr_data = 8'h21;
    mem[100] = 8'h21;
    do_start(1'b1);
    wr_valid = 1'b0;
    stream_collect(0);
    check_events("write_with_start");
    finish_result(8'h02, 1);
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_result_path();
    test_backpressure();
    test_back_to_back();
    test_ready_gating();
    test_random();
    test_mid_reset();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
